// File: rtl/elbeth_pipe_stage.sv
// Handshaked pipeline-stage register for the ELBETH pipeline: data payload plus
// separately-flushable control payload, optional 2-entry skid buffer, bubble counter.
module elbeth_pipe_stage #(
  parameter int unsigned         DATA_W   = 137,
  parameter int unsigned         CTRL_W   = 13,
  parameter logic [CTRL_W-1:0]   CTRL_RST = '0,
  parameter bit                  SKID     = 1'b1,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_stall,
  input  logic              ctrl_flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  // ONE = output register occupied; FULL = output register and skid entry occupied.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CTRL_W-1:0]   out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;

  logic skid_valid;
  logic accept;
  logic emit;

  assign out_valid    = (state_q != ST_EMPTY);
  assign skid_valid   = (state_q == ST_FULL);
  assign out_data     = out_data_q;
  assign out_ctrl     = out_ctrl_q;
  assign bubble_count = bubble_q;

  // With the skid buffer, in_ready depends only on a flop, never on out_ready.
  always_comb begin
    if (SKID) in_ready = rst & ~ctrl_stall & ~skid_valid;
    else      in_ready = rst & ~ctrl_stall & (~out_valid | out_ready);
  end

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (ctrl_flush) begin
      // Only the control side is squashed; data registers keep their contents.
      state_d     = ST_EMPTY;
      out_ctrl_d  = CTRL_RST;
      skid_ctrl_d = CTRL_RST;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d    = ST_ONE;
            out_data_d = in_data;
            out_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            out_data_d = in_data;
            out_ctrl_d = in_ctrl;
          end else if (accept) begin
            // Reachable only with SKID=1; without it in_ready requires out_ready.
            state_d     = ST_FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d    = ST_ONE;
            out_data_d = skid_data_q;
            out_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (!out_valid && out_ready && !ctrl_flush && (bubble_q != {CNT_W{1'b1}}))
      bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the payload registers are reset as well, because out_data must read
      // zero after reset; they are plain flops, not a memory array.
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_ctrl_q  <= CTRL_RST;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_RST;
      bubble_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      bubble_q    <= bubble_d;
    end
  end

endmodule

// File: tb/tb_elbeth_pipe_stage.sv
// Bench for elbeth_pipe_stage: SKID=1 and SKID=0 instances on shared stimulus,
// each compared every cycle against a queue-level model, plus literal checks.
module tb_elbeth_pipe_stage;

  localparam int unsigned       DATA_W   = 137;
  localparam int unsigned       CTRL_W   = 13;
  localparam int unsigned       CNT_W    = 16;
  localparam logic [CTRL_W-1:0] CTRL_RST = '0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  // Stage modelled as a bounded FIFO plus the last payload presented downstream.
  typedef struct packed {
    entry_t [1:0]      e;
    logic [1:0]        n;
    logic [DATA_W-1:0] dd;
    logic [CTRL_W-1:0] dc;
    logic [CNT_W-1:0]  bub;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ctrl_stall = 1'b0;
  logic ctrl_flush = 1'b0;
  logic in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic out_ready = 1'b0;

  logic              in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DATA_W-1:0] out_data1, out_data0;
  logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
  logic [CNT_W-1:0]  bubble1, bubble0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  model_t mdl [2];
  entry_t din_e;

  assign din_e = {in_data, in_ctrl};

  always #5 clk = ~clk;

  elbeth_pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST),
                      .SKID(1'b1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .bubble_count(bubble1));

  elbeth_pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST),
                      .SKID(1'b0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .bubble_count(bubble0));

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic model_t reset_model();
    model_t m;
    m    = '0;
    m.dc = CTRL_RST;
    return m;
  endfunction

  function automatic logic model_ready(model_t m, bit skid, logic st, logic ordy, logic r);
    if (!r || st) return 1'b0;
    if (skid)     return (m.n < 2'd2);
    return (m.n == 2'd0) || ordy;
  endfunction

  function automatic model_t step(model_t m, bit skid, logic iv, entry_t din,
                                  logic ordy, logic st, logic fl);
    logic emit, acc;
    emit = (m.n != 2'd0) && ordy;
    acc  = iv && model_ready(m, skid, st, ordy, 1'b1);
    if (m.n == 2'd0 && ordy && !fl && m.bub != {CNT_W{1'b1}}) m.bub = m.bub + 1'b1;
    if (fl) begin
      m.n  = 2'd0;
      m.dc = CTRL_RST;
      return m;
    end
    if (emit) begin
      m.e[0] = m.e[1];
      m.n    = m.n - 2'd1;
    end
    if (acc) begin
      m.e[m.n[0]] = din;
      m.n         = m.n + 2'd1;
    end
    if (m.n != 2'd0) begin
      m.dd = m.e[0].data;
      m.dc = m.e[0].ctrl;
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) mdl[k] <= reset_model();
    end else begin
      for (int k = 0; k < 2; k++)
        mdl[k] <= step(mdl[k], k == 1, in_valid, din_e, out_ready, ctrl_stall, ctrl_flush);
    end
  end

  task automatic cmp(input int k, input logic ir, input logic ov, input logic [DATA_W-1:0] od,
                     input logic [CTRL_W-1:0] oc, input logic [CNT_W-1:0] bc);
    check($sformatf("skid%0d.in_ready", k), 160'(ir),
          160'(model_ready(mdl[k], k == 1, ctrl_stall, out_ready, rst)));
    check($sformatf("skid%0d.out_valid", k), 160'(ov), 160'(mdl[k].n != 2'd0));
    check($sformatf("skid%0d.out_data", k), 160'(od), 160'(mdl[k].dd));
    check($sformatf("skid%0d.out_ctrl", k), 160'(oc), 160'(mdl[k].dc));
    check($sformatf("skid%0d.bubble_count", k), 160'(bc), 160'(mdl[k].bub));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(1, in_ready1, out_valid1, out_data1, out_ctrl1, bubble1);
      cmp(0, in_ready0, out_valid0, out_data0, out_ctrl0, bubble0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic st, input logic fl);
    in_valid   = v;
    in_data    = d;
    in_ctrl    = c;
    out_ready  = ordy;
    ctrl_stall = st;
    ctrl_flush = fl;
  endtask

  initial begin
    logic [159:0] rnd;

    // Reset state
    repeat (3) tick();
    check("rst.out_valid", 160'(out_valid1), 160'(0));
    check("rst.out_data", 160'(out_data1), 160'(0));
    check("rst.out_ctrl", 160'(out_ctrl1), 160'(CTRL_RST));
    check("rst.bubble", 160'(bubble1), 160'(0));
    check("rst.in_ready_low", 160'(in_ready1), 160'(0));
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    tick();
    check("rst.in_ready_after", 160'(in_ready1), 160'(1));

    // Streaming 0,1,2,... with out_ready high on both instances
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1, 1'b0, 1'b0);
      tick();
      check("stream.out_valid", 160'(out_valid1), 160'(1));
      check("stream.out_data", 160'(out_data1), 160'(i));
      check("stream.in_ready", 160'(in_ready1), 160'(1));
      check("stream0.out_data", 160'(out_data0), 160'(i));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();

    // Backpressure: A then B with out_ready low fills the skid buffer
    drive(1'b1, DATA_W'(16'hAAAA), '0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, DATA_W'(16'hBBBB), '0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, DATA_W'(16'hCCCC), '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("bp.full_in_ready", 160'(in_ready1), 160'(0));
    check("bp.hold_a", 160'(out_data1), 160'(16'hAAAA));
    tick();
    check("bp.still_a", 160'(out_data1), 160'(16'hAAAA));
    check("bp.still_full", 160'(in_ready1), 160'(0));
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("bp.emit_b", 160'(out_data1), 160'(16'hBBBB));
    check("bp.ready_back", 160'(in_ready1), 160'(1));
    tick();
    check("bp.drained", 160'(out_valid1), 160'(0));

    // Stall with one held entry
    drive(1'b1, DATA_W'(16'hD00D), '0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, DATA_W'(16'hEEEE), '0, 1'b1, 1'b1, 1'b0);
    #1;
    check("stall.in_ready", 160'(in_ready1), 160'(0));
    check("stall.held_d", 160'(out_data1), 160'(16'hD00D));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.no_valid", 160'(out_valid1), 160'(0));
      check("stall.in_ready_low", 160'(in_ready1), 160'(0));
    end
    check("stall.data_kept", 160'(out_data1), 160'(16'hD00D));
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();

    // Flush from FULL with a concurrent input, then flush+stall
    for (int s = 0; s < 2; s++) begin
      drive(1'b1, DATA_W'(16'hF001), 13'h1FFF, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, DATA_W'(16'hF002), 13'h1FFF, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, DATA_W'(16'h6666), 13'h1FFF, 1'b0, s[0], 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #1;
      check("flush.out_valid", 160'(out_valid1), 160'(0));
      check("flush.out_ctrl", 160'(out_ctrl1), 160'(0));
      check("flush.skid_empty", 160'(in_ready1), 160'(1));
      check("flush.data_kept", 160'(out_data1), 160'(16'hF001));
      tick();
      check("flush.input_lost", 160'(out_valid1), 160'(0));
    end

    // Asynchronous reset from FULL, between clock edges
    drive(1'b1, DATA_W'(16'h1111), 13'h0ABC, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, DATA_W'(16'h2222), 13'h0ABC, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst.out_valid", 160'(out_valid1), 160'(0));
    check("arst.out_ctrl", 160'(out_ctrl1), 160'(0));
    check("arst.in_ready", 160'(in_ready1), 160'(0));
    check("arst.bubble", 160'(bubble1), 160'(0));
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("arst.in_ready_after", 160'(in_ready1), 160'(1));

    // Randomized traffic in four back-pressure regimes
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        drive($urandom_range(0, 3) != 0, rnd[DATA_W-1:0], CTRL_W'($urandom),
              $urandom_range(0, 3) < ph + 1, $urandom_range(0, 7) == 0,
              $urandom_range(0, 19) == 0);
        tick();
      end
    end

    // Long starvation: bubble counter must saturate and hold
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (70000) tick();
    check("sat.bubble1", 160'(bubble1), 160'(16'hFFFF));
    check("sat.bubble0", 160'(bubble0), 160'(16'hFFFF));
    repeat (5) tick();
    check("sat.hold", 160'(bubble0), 160'(16'hFFFF));

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
